// File: rtl/led_count_arbiter.sv
// led_count_arbiter
//
// Shares one LED counting engine between two requesters. A round-robin
// arbiter picks an owner. The owner's pass then counts led from 0 up to
// MAX_COUNT, advancing once every TICK_DIV clk cycles. When the pass is
// complete, the owner gets a one-cycle done pulse. If the owner drops its
// request during a pass, the pass aborts with no done pulse.
// Everything runs in the clk domain. The tick is a clock enable, not a
// derived clock. All outputs come straight from flops.
//
// Ports:
//   clk    input   1      system clock
//   rst    input   1      asynchronous, active-high reset
//   req    input   2      level request per requester; held until done
//   grant  output  2      one-hot owner of the counter, 00 when unowned
//   led    output  CNT_W  current count value
//   busy   output  1      high while a pass is running
//   done   output  2      one-cycle completion pulse to the owner
module led_count_arbiter #(
    parameter int TICK_DIV  = 1500000,
    parameter int DIV_W     = 24,
    parameter int CNT_W     = 4,
    parameter int MAX_COUNT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] led,
    output logic             busy,
    output logic [1:0]       done
);

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LED_MAX   = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [CNT_W-1:0] led_q, led_d;
    logic             busy_q, busy_d;
    logic [1:0]       done_q, done_d;
    logic             last_q, last_d;
    logic [DIV_W-1:0] presc_q, presc_d;

    logic             tick;
    logic             owner_active;
    logic             winner;

    // The tick fires on the last prescaler count of each tick period.
    // The pass stays alive only while the current owner keeps its
    // request high.
    always_comb begin
        tick         = (presc_q == TICK_LAST);
        owner_active = |(req & grant_q);
    end

    // Round-robin choice. A lone requester always wins. On a tie, the
    // requester that did not win last time goes first.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b10) begin
            winner = 1'b1;
        end else if (req == 2'b11) begin
            winner = ~last_q;
        end
    end

    // Next-state and next-output logic. Any state other than RUN clears
    // the prescaler. An abort is checked before the tick, so it wins when
    // both happen in the same cycle. The unused state encoding falls into
    // the default branch and returns to IDLE with all outputs cleared.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = 2'b00;
        last_d  = last_q;
        presc_d = presc_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                led_d   = '0;
                presc_d = '0;
                if (|req) begin
                    grant_d = winner ? 2'b10 : 2'b01;
                    last_d  = winner;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!owner_active) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    busy_d  = 1'b0;
                    led_d   = '0;
                    presc_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + DIV_W'(1);
                    if (tick) begin
                        if (led_q < LED_MAX) begin
                            led_d = led_q + CNT_W'(1);
                        end else begin
                            state_d = ST_DONE;
                            done_d  = grant_q;
                            grant_d = 2'b00;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
                led_d   = '0;
                presc_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
                led_d   = '0;
                presc_d = '0;
            end
        endcase
    end

    // State and output registers. last resets to 1 so that requester 0
    // wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 2'b00;
            last_q  <= 1'b1;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
            presc_q <= presc_d;
        end
    end

    assign grant = grant_q;
    assign led   = led_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_led_count_arbiter.sv
// tb_led_count_arbiter
//
// Self-checking bench for led_count_arbiter. Instance dut_a uses
// TICK_DIV=4 and MAX_COUNT=3. Instance dut_b uses TICK_DIV=1 and
// MAX_COUNT=15, to cover the boundary case. Expected values come from
// three sources:
//   - a literal vector table for a single pass;
//   - hand-written sequences for the corner cases;
//   - a behavioural model of dut_a. The model keeps only the owner, the
//     cycles elapsed in the pass, and the last winner. It derives led
//     from elapsed / TICK_DIV.
module tb_led_count_arbiter;

    localparam int TICK_A = 4;
    localparam int MAX_A  = 3;
    localparam int PASS_A = (MAX_A + 1) * TICK_A;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] grant;
    logic [3:0] led;
    logic       busy;
    logic [1:0] done;

    logic [1:0] req_b;
    logic [1:0] grant_b;
    logic [3:0] led_b;
    logic       busy_b;
    logic [1:0] done_b;

    int checks;
    int failures;

    // Behavioural model state for dut_a.
    int m_owner;
    int m_elapsed;
    int m_done_owner;
    int m_last;

    typedef struct {
        logic [1:0] req;
        logic [1:0] grant;
        logic [3:0] led;
        logic       busy;
        logic [1:0] done;
    } vec_t;

    vec_t pass_tbl [18];

    led_count_arbiter #(
        .TICK_DIV (TICK_A),
        .DIV_W    (24),
        .CNT_W    (4),
        .MAX_COUNT(MAX_A)
    ) dut_a (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .grant(grant),
        .led  (led),
        .busy (busy),
        .done (done)
    );

    led_count_arbiter #(
        .TICK_DIV (1),
        .DIV_W    (24),
        .CNT_W    (4),
        .MAX_COUNT(15)
    ) dut_b (
        .clk  (clk),
        .rst  (rst),
        .req  (req_b),
        .grant(grant_b),
        .led  (led_b),
        .busy (busy_b),
        .done (done_b)
    );

    // 10 ns clock. Inputs change and outputs are sampled on the falling
    // edge, away from the active rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_owner      = -1;
        m_elapsed    = 0;
        m_done_owner = -1;
        m_last       = 1;
    endtask

    // One clock edge of the specification's rules, in pass-level terms.
    task automatic modelStep(input logic [1:0] r);
        int w;
        if (m_done_owner >= 0) begin
            m_done_owner = -1;
        end else if (m_owner < 0) begin
            if (r != 2'b00) begin
                if (r == 2'b01)      w = 0;
                else if (r == 2'b10) w = 1;
                else                 w = (m_last == 1) ? 0 : 1;
                m_owner   = w;
                m_last    = w;
                m_elapsed = 0;
            end
        end else if (r[m_owner] == 1'b0) begin
            m_owner = -1;
        end else begin
            m_elapsed++;
            if (m_elapsed == PASS_A) begin
                m_done_owner = m_owner;
                m_owner      = -1;
            end
        end
    endtask

    task automatic checkOutput(input string name);
        int e_grant, e_led, e_busy, e_done;
        e_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
        e_busy  = (m_owner >= 0) ? 1 : 0;
        e_done  = (m_done_owner >= 0) ? (1 << m_done_owner) : 0;
        if (m_owner >= 0)           e_led = m_elapsed / TICK_A;
        else if (m_done_owner >= 0) e_led = MAX_A;
        else                        e_led = 0;
        cmp({name, ".grant"}, int'(grant), e_grant);
        cmp({name, ".led"},   int'(led),   e_led);
        cmp({name, ".busy"},  int'(busy),  e_busy);
        cmp({name, ".done"},  int'(done),  e_done);
    endtask

    // Drive req for one cycle, advance the model with the same value,
    // then compare dut_a against the model on the falling edge.
    task automatic applyStimulus(input logic [1:0] r, input string name);
        req = r;
        @(posedge clk);
        modelStep(r);
        @(negedge clk);
        checkOutput(name);
    endtask

    task automatic doReset();
        @(negedge clk);
        req   = 2'b00;
        req_b = 2'b00;
        rst   = 1'b1;
        modelReset();
        @(negedge clk);
        checkOutput("reset_hold");
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] done_seen [$];
        int         done_cyc  [$];
        int         grant_cyc [$];
        logic [1:0] prev_grant;
        logic [1:0] exp_order [4];
        logic [1:0] r;

        checks   = 0;
        failures = 0;
        modelReset();

        // Reset must act asynchronously, before any clock edge, even
        // while both requesters are active.
        req   = 2'b11;
        req_b = 2'b11;
        rst   = 1'b0;
        #1 rst = 1'b1;
        #1;
        cmp("async_reset.grant", int'(grant), 0);
        cmp("async_reset.led",   int'(led),   0);
        cmp("async_reset.busy",  int'(busy),  0);
        cmp("async_reset.done",  int'(done),  0);
        cmp("async_reset.grant_b", int'(grant_b), 0);
        doReset();

        // Single pass, table-driven. Row i is RUN cycle i+1 up to row 15.
        // Row 16 is DONE and row 17 is the IDLE that follows.
        pass_tbl[0]  = '{2'b01, 2'b01, 4'd0, 1'b1, 2'b00};
        pass_tbl[1]  = '{2'b01, 2'b01, 4'd0, 1'b1, 2'b00};
        pass_tbl[2]  = '{2'b01, 2'b01, 4'd0, 1'b1, 2'b00};
        pass_tbl[3]  = '{2'b01, 2'b01, 4'd0, 1'b1, 2'b00};
        pass_tbl[4]  = '{2'b01, 2'b01, 4'd1, 1'b1, 2'b00};
        pass_tbl[5]  = '{2'b01, 2'b01, 4'd1, 1'b1, 2'b00};
        pass_tbl[6]  = '{2'b01, 2'b01, 4'd1, 1'b1, 2'b00};
        pass_tbl[7]  = '{2'b01, 2'b01, 4'd1, 1'b1, 2'b00};
        pass_tbl[8]  = '{2'b01, 2'b01, 4'd2, 1'b1, 2'b00};
        pass_tbl[9]  = '{2'b01, 2'b01, 4'd2, 1'b1, 2'b00};
        pass_tbl[10] = '{2'b01, 2'b01, 4'd2, 1'b1, 2'b00};
        pass_tbl[11] = '{2'b01, 2'b01, 4'd2, 1'b1, 2'b00};
        pass_tbl[12] = '{2'b01, 2'b01, 4'd3, 1'b1, 2'b00};
        pass_tbl[13] = '{2'b01, 2'b01, 4'd3, 1'b1, 2'b00};
        pass_tbl[14] = '{2'b01, 2'b01, 4'd3, 1'b1, 2'b00};
        pass_tbl[15] = '{2'b01, 2'b01, 4'd3, 1'b1, 2'b00};
        pass_tbl[16] = '{2'b01, 2'b00, 4'd3, 1'b0, 2'b01};
        pass_tbl[17] = '{2'b00, 2'b00, 4'd0, 1'b0, 2'b00};
        for (int i = 0; i < 18; i++) begin
            applyStimulus(pass_tbl[i].req, "pass_model");
            cmp($sformatf("pass_tbl[%0d].grant", i), int'(grant), int'(pass_tbl[i].grant));
            cmp($sformatf("pass_tbl[%0d].led", i),   int'(led),   int'(pass_tbl[i].led));
            cmp($sformatf("pass_tbl[%0d].busy", i),  int'(busy),  int'(pass_tbl[i].busy));
            cmp($sformatf("pass_tbl[%0d].done", i),  int'(done),  int'(pass_tbl[i].done));
        end

        // Abort: requester 1 drops its request in RUN cycle 6 (led=1).
        // The next tie must then go to requester 0, because last=1.
        applyStimulus(2'b10, "abort_grant");
        cmp("abort.grant", int'(grant), 2);
        for (int i = 0; i < 5; i++) applyStimulus(2'b10, "abort_run");
        cmp("abort.cycle6_led", int'(led), 1);
        applyStimulus(2'b00, "abort_drop");
        cmp("abort.after_grant", int'(grant), 0);
        cmp("abort.after_led",   int'(led),   0);
        cmp("abort.after_done",  int'(done),  0);
        applyStimulus(2'b11, "abort_retie");
        cmp("abort.retie_grant", int'(grant), 1);

        // Asynchronous reset while led=2. Requester 0 is already granted
        // and at RUN cycle 1, so eight more cycles reach RUN cycle 9.
        for (int i = 0; i < 8; i++) applyStimulus(2'b01, "midreset_run");
        cmp("midreset.led_before", int'(led), 2);
        #2 rst = 1'b1;
        #1;
        cmp("midreset.led",   int'(led),   0);
        cmp("midreset.grant", int'(grant), 0);
        cmp("midreset.busy",  int'(busy),  0);
        cmp("midreset.done",  int'(done),  0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b01, "midreset_fresh");
        cmp("midreset.fresh_grant", int'(grant), 1);
        cmp("midreset.fresh_led",   int'(led),   0);
        for (int i = 0; i < PASS_A + 1; i++) applyStimulus(2'b01, "midreset_finish");

        // Contention from reset: both requesters hold their requests.
        // Grants and done pulses must alternate 01,10,01,10, and each
        // next grant must arrive two cycles after the previous done.
        doReset();
        prev_grant = 2'b00;
        for (int c = 1; c <= 4 * (PASS_A + 2); c++) begin
            applyStimulus(2'b11, "contend");
            if (done != 2'b00) begin
                done_seen.push_back(done);
                done_cyc.push_back(c);
            end
            if (grant != 2'b00 && prev_grant == 2'b00) grant_cyc.push_back(c);
            prev_grant = grant;
        end
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
        cmp("contend.done_count", done_seen.size(), 4);
        for (int k = 0; k < 4 && k < done_seen.size(); k++) begin
            cmp($sformatf("contend.done[%0d]", k), int'(done_seen[k]), int'(exp_order[k]));
        end
        for (int k = 0; k < 3 && k + 1 < grant_cyc.size() && k < done_cyc.size(); k++) begin
            cmp($sformatf("contend.gap[%0d]", k), grant_cyc[k+1] - done_cyc[k], 2);
        end

        // Randomized traffic checked against the model. Requests change
        // rarely, so most passes complete and some abort.
        doReset();
        r = 2'b00;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) r = 2'($urandom_range(0, 3));
            applyStimulus(r, "random");
        end

        // Boundary on dut_b (TICK_DIV=1, MAX_COUNT=15): led steps every
        // cycle. Sixteen RUN cycles are followed by DONE with led still 15.
        doReset();
        req_b = 2'b01;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'b00, "boundary_idle_a");
            cmp($sformatf("boundary.led[%0d]", i), int'(led_b), i);
            cmp($sformatf("boundary.busy[%0d]", i), int'(busy_b), 1);
            cmp($sformatf("boundary.grant[%0d]", i), int'(grant_b), 1);
        end
        applyStimulus(2'b00, "boundary_idle_a");
        cmp("boundary.done",      int'(done_b), 1);
        cmp("boundary.done_led",  int'(led_b),  15);
        cmp("boundary.done_busy", int'(busy_b), 0);
        req_b = 2'b00;
        applyStimulus(2'b00, "boundary_idle_a");
        cmp("boundary.after_done", int'(done_b), 0);
        cmp("boundary.after_led",  int'(led_b),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
